// File: rtl/rv_rr_arb_mux.sv
// rv_rr_arb_mux: merges NUM_CH ready/valid sender channels into one receiver.
// A round-robin arbiter picks one channel per cycle. Accepted beats flow into a
// registered main output stage, backed by a one-entry skid register.
// Every beat is tagged with its source channel on m_id.
// Optional packet locking is enabled by defining RV_ARB_PKT_LOCK_EN. While a
// channel is mid-packet, it keeps the grant until its s_last beat is accepted.
module rv_rr_arb_mux #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CH     = 4,
  parameter int ID_WIDTH   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_CH-1:0]            s_valid,
  input  logic [NUM_CH*DATA_WIDTH-1:0] s_data,
  input  logic [NUM_CH-1:0]            s_last,
  output logic [NUM_CH-1:0]            s_ready,
  output logic                         m_valid,
  output logic [DATA_WIDTH-1:0]        m_data,
  output logic [ID_WIDTH-1:0]          m_id,
  output logic                         m_last,
  input  logic                         m_ready
);

  // Round-robin pointer: the channel that gets first look in the search.
  logic [ID_WIDTH-1:0]   r_rr_ptr;

  // Main output register; it drives the m_* ports directly.
  logic                  r_main_valid;
  logic [DATA_WIDTH-1:0] r_main_data;
  logic [ID_WIDTH-1:0]   r_main_id;
  logic                  r_main_last;

  // Skid register. It catches a beat that was accepted while main was stalled.
  logic                  r_skid_valid;
  logic [DATA_WIDTH-1:0] r_skid_data;
  logic [ID_WIDTH-1:0]   r_skid_id;
  logic                  r_skid_last;

`ifdef RV_ARB_PKT_LOCK_EN
  // Packet lock state: set by a non-last beat, cleared by the last beat.
  logic                  r_lock;
  logic [ID_WIDTH-1:0]   r_lock_ch;
`endif

  // Arbiter search results.
  // "hi" covers channels at or above the pointer; "lo" covers all channels.
  logic                  w_hi_valid;
  logic [ID_WIDTH-1:0]   w_hi_idx;
  logic                  w_lo_valid;
  logic [ID_WIDTH-1:0]   w_lo_idx;

  logic                  w_grant_valid;
  logic [ID_WIDTH-1:0]   w_grant_idx;
  logic [NUM_CH-1:0]     w_grant_oh;
  logic [DATA_WIDTH-1:0] w_beat_data;
  logic                  w_beat_last;
  logic                  w_accept;
  logic [ID_WIDTH-1:0]   w_next_ptr;

  // Find the lowest valid channel at or above the pointer, and the lowest
  // valid channel overall. The second one covers the wrap-around case.
  always_comb begin
    w_hi_valid = 1'b0;
    w_hi_idx   = '0;
    w_lo_valid = 1'b0;
    w_lo_idx   = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (s_valid[i]) begin
        w_lo_valid = 1'b1;
        w_lo_idx   = ID_WIDTH'(i);
        if (ID_WIDTH'(i) >= r_rr_ptr) begin
          w_hi_valid = 1'b1;
          w_hi_idx   = ID_WIDTH'(i);
        end
      end
    end
  end

  // Pick the granted channel.
  // A held packet lock overrides the round-robin choice.
  always_comb begin
    w_grant_valid = w_hi_valid | w_lo_valid;
    w_grant_idx   = w_hi_valid ? w_hi_idx : w_lo_idx;
`ifdef RV_ARB_PKT_LOCK_EN
    if (r_lock) begin
      w_grant_valid = 1'b0;
      w_grant_idx   = r_lock_ch;
      for (int i = 0; i < NUM_CH; i++) begin
        if ((ID_WIDTH'(i) == r_lock_ch) && s_valid[i]) begin
          w_grant_valid = 1'b1;
        end
      end
    end
`endif
  end

  // Decode the grant to one-hot form and select the granted beat.
  always_comb begin
    w_grant_oh  = '0;
    w_beat_data = '0;
    w_beat_last = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_grant_valid && (ID_WIDTH'(i) == w_grant_idx)) begin
        w_grant_oh[i] = 1'b1;
        w_beat_data   = s_data[i*DATA_WIDTH +: DATA_WIDTH];
        w_beat_last   = s_last[i];
      end
    end
  end

  // A full skid register blocks all senders.
  // Otherwise only the granted channel sees ready.
  assign s_ready    = w_grant_oh & {NUM_CH{~r_skid_valid}};
  assign w_accept   = w_grant_valid & ~r_skid_valid;
  assign w_next_ptr = (w_grant_idx == ID_WIDTH'(NUM_CH - 1)) ? '0
                                                             : w_grant_idx + 1'b1;

  // Move the pointer just past the channel that was served.
  // When locking, it only moves at packet boundaries.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rr_ptr <= '0;
    end else if (w_accept) begin
`ifdef RV_ARB_PKT_LOCK_EN
      if (w_beat_last) begin
        r_rr_ptr <= w_next_ptr;
      end
`else
      r_rr_ptr <= w_next_ptr;
`endif
    end
  end

`ifdef RV_ARB_PKT_LOCK_EN
  // Keep the grant on a channel from its first beat until its last beat.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lock    <= 1'b0;
      r_lock_ch <= '0;
    end else if (w_accept) begin
      if (w_beat_last) begin
        r_lock <= 1'b0;
      end else begin
        r_lock    <= 1'b1;
        r_lock_ch <= w_grant_idx;
      end
    end
  end
`endif

  // Two-entry output stage.
  // A draining skid has priority, so beats keep their acceptance order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_main_valid <= 1'b0;
      r_main_data  <= '0;
      r_main_id    <= '0;
      r_main_last  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
      r_skid_id    <= '0;
      r_skid_last  <= 1'b0;
    end else if (r_skid_valid) begin
      if (m_ready) begin
        r_main_data  <= r_skid_data;
        r_main_id    <= r_skid_id;
        r_main_last  <= r_skid_last;
        r_skid_valid <= 1'b0;
      end
    end else if (w_accept) begin
      if (!r_main_valid || m_ready) begin
        r_main_valid <= 1'b1;
        r_main_data  <= w_beat_data;
        r_main_id    <= w_grant_idx;
        r_main_last  <= w_beat_last;
      end else begin
        r_skid_valid <= 1'b1;
        r_skid_data  <= w_beat_data;
        r_skid_id    <= w_grant_idx;
        r_skid_last  <= w_beat_last;
      end
    end else if (r_main_valid && m_ready) begin
      r_main_valid <= 1'b0;
    end
  end

  assign m_valid = r_main_valid;
  assign m_data  = r_main_data;
  assign m_id    = r_main_id;
  assign m_last  = r_main_last;

endmodule
